// File: rtl/seq_rec_pkg.sv
// Shared types and constants for the serial run detector.
package seq_rec_pkg;

    // FSM encoding: IDLE until the first accepted bit, then RUN forever (until reset).
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Polarity filter selections.
    localparam int unsigned MODE_ANY   = 0;
    localparam int unsigned MODE_ONES  = 1;
    localparam int unsigned MODE_ZEROS = 2;

    // Bits needed to hold a run length of 0..n.
    function automatic int unsigned run_len_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: reset > clr > load1 > inc.
module sat_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             load1,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    // Count register: clear, restart at one, or step up until MAX.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load1) begin
            r_count <= WIDTH'(1);
        end else if (inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_run_detector.sv
// Moore run detector: D_out is high while the last RUN_LEN accepted bits are equal
// and the run value passes the polarity filter selected by MODE.
module seq_run_detector
    import seq_rec_pkg::*;
#(
    parameter int unsigned RUN_LEN = 2,
    parameter int unsigned MODE    = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               D_in,
    input  logic                               clr_count,
    output logic                               D_out,
    output logic                               det_pulse,
    output logic                               run_bit,
    output logic [run_len_width(RUN_LEN)-1:0]  run_len,
    output logic [CNT_W-1:0]                   det_count
);

    localparam int unsigned           LEN_W   = run_len_width(RUN_LEN);
    // A run qualifies on the edge that takes its length from RUN_LEN-1 to RUN_LEN.
    localparam logic [LEN_W-1:0]      LEN_PRE = LEN_W'(RUN_LEN - 1);
    localparam int unsigned           CNT_MAX = (1 << CNT_W) - 1;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_run_bit;
    logic             w_run_bit_next;
    logic             r_d_out;
    logic             w_d_out_next;
    logic             r_pulse;
    logic             w_rise;
    logic             w_len_inc;
    logic             w_len_load1;
    logic             w_pol_ok;
    logic [LEN_W-1:0] w_run_len;

    // Polarity filter on the value of the current run.
    always_comb begin
        w_pol_ok = 1'b1;
        if (MODE == MODE_ANY) begin
            w_pol_ok = 1'b1;
        end else if (MODE == MODE_ONES) begin
            w_pol_ok = r_run_bit;
        end else if (MODE == MODE_ZEROS) begin
            w_pol_ok = ~r_run_bit;
        end
    end

    // Next-state, run tracking and detection decode; nothing moves unless en=1.
    always_comb begin
        w_state_next   = r_state;
        w_run_bit_next = r_run_bit;
        w_d_out_next   = r_d_out;
        w_rise         = 1'b0;
        w_len_inc      = 1'b0;
        w_len_load1    = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next   = ST_RUN;
                    w_run_bit_next = D_in;
                    w_len_load1    = 1'b1;
                end
                ST_RUN: begin
                    if (D_in == r_run_bit) begin
                        w_len_inc = 1'b1;
                        // Saturated runs never hit LEN_PRE again, so no re-pulse.
                        if ((w_run_len == LEN_PRE) && w_pol_ok) begin
                            w_rise       = 1'b1;
                            w_d_out_next = 1'b1;
                        end
                    end else begin
                        w_run_bit_next = D_in;
                        w_len_load1    = 1'b1;
                        w_d_out_next   = 1'b0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, run value and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_run_bit <= 1'b0;
            r_d_out   <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_run_bit <= w_run_bit_next;
            r_d_out   <= w_d_out_next;
            r_pulse   <= w_rise;
        end
    end

    sat_counter #(
        .WIDTH (LEN_W),
        .MAX   (RUN_LEN)
    ) u_len_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc     (w_len_inc),
        .clr     (1'b0),
        .load1   (w_len_load1),
        .o_count (w_run_len)
    );

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (CNT_MAX)
    ) u_det_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc     (w_rise),
        .clr     (clr_count),
        .load1   (1'b0),
        .o_count (det_count)
    );

    assign D_out     = r_d_out;
    assign det_pulse = r_pulse;
    assign run_bit   = r_run_bit;
    assign run_len   = w_run_len;

endmodule

// File: tb/tb_seq_run_detector.sv
// Directed bench for seq_run_detector: four parameterisations share one stimulus stream.
module tb_seq_run_detector;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic D_in = 1'b0;
    logic clr_count = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    // a: RUN_LEN=3, MODE0
    logic       a_dout, a_pulse, a_bit;
    logic [1:0] a_len;
    logic [7:0] a_cnt;
    // b: RUN_LEN=3, MODE1
    logic       b_dout, b_pulse, b_bit;
    logic [1:0] b_len;
    logic [7:0] b_cnt;
    // c: RUN_LEN=2, MODE0, CNT_W=2
    logic       c_dout, c_pulse, c_bit;
    logic [1:0] c_len;
    logic [1:0] c_cnt;
    // d: RUN_LEN=4, MODE2
    logic       d_dout, d_pulse, d_bit;
    logic [2:0] d_len;
    logic [7:0] d_cnt;

    seq_run_detector #(.RUN_LEN(3), .MODE(0), .CNT_W(8)) u_a (
        .clock(clock), .reset(reset), .en(en), .D_in(D_in), .clr_count(clr_count),
        .D_out(a_dout), .det_pulse(a_pulse), .run_bit(a_bit), .run_len(a_len),
        .det_count(a_cnt)
    );
    seq_run_detector #(.RUN_LEN(3), .MODE(1), .CNT_W(8)) u_b (
        .clock(clock), .reset(reset), .en(en), .D_in(D_in), .clr_count(clr_count),
        .D_out(b_dout), .det_pulse(b_pulse), .run_bit(b_bit), .run_len(b_len),
        .det_count(b_cnt)
    );
    seq_run_detector #(.RUN_LEN(2), .MODE(0), .CNT_W(2)) u_c (
        .clock(clock), .reset(reset), .en(en), .D_in(D_in), .clr_count(clr_count),
        .D_out(c_dout), .det_pulse(c_pulse), .run_bit(c_bit), .run_len(c_len),
        .det_count(c_cnt)
    );
    seq_run_detector #(.RUN_LEN(4), .MODE(2), .CNT_W(8)) u_d (
        .clock(clock), .reset(reset), .en(en), .D_in(D_in), .clr_count(clr_count),
        .D_out(d_dout), .det_pulse(d_pulse), .run_bit(d_bit), .run_len(d_len),
        .det_count(d_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one bit across a rising edge, then settle for sampling.
    task automatic tick(input logic e, input logic d);
        en   = e;
        D_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        int hi;
        int np;

        // Reset state (reset held with en=1, D_in=1 must still win)
        do_reset();
        chk("rst_dout", 32'(a_dout), 0);
        chk("rst_pulse", 32'(a_pulse), 0);
        chk("rst_bit", 32'(a_bit), 0);
        chk("rst_len", 32'(a_len), 0);
        chk("rst_cnt", 32'(a_cnt), 0);

        // RUN_LEN=3 MODE0: 1,1,1,1,0
        tick(1'b1, 1'b1);
        chk("s1_e1_dout", 32'(a_dout), 0);
        chk("s1_e1_len", 32'(a_len), 1);
        tick(1'b1, 1'b1);
        chk("s1_e2_dout", 32'(a_dout), 0);
        chk("s1_e2_len", 32'(a_len), 2);
        tick(1'b1, 1'b1);
        chk("s1_e3_dout", 32'(a_dout), 1);
        chk("s1_e3_pulse", 32'(a_pulse), 1);
        chk("s1_e3_cnt", 32'(a_cnt), 1);
        tick(1'b1, 1'b1);
        chk("s1_e4_dout", 32'(a_dout), 1);
        chk("s1_e4_pulse", 32'(a_pulse), 0);
        chk("s1_e4_len", 32'(a_len), 3);
        tick(1'b1, 1'b0);
        chk("s1_e5_dout", 32'(a_dout), 0);
        chk("s1_e5_bit", 32'(a_bit), 0);
        chk("s1_e5_len", 32'(a_len), 1);
        chk("s1_e5_cnt", 32'(a_cnt), 1);

        // RUN_LEN=3 MODE1: 0,0,0,0,1,1,1
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("s2_zero3_dout", 32'(b_dout), 0);
        chk("s2_zero3_pulse", 32'(b_pulse), 0);
        tick(1'b1, 1'b0);
        chk("s2_zero4_dout", 32'(b_dout), 0);
        chk("s2_zero4_len", 32'(b_len), 3);
        chk("s2_zero4_bit", 32'(b_bit), 0);
        tick(1'b1, 1'b1);
        chk("s2_one1_len", 32'(b_len), 1);
        tick(1'b1, 1'b1);
        chk("s2_one2_dout", 32'(b_dout), 0);
        tick(1'b1, 1'b1);
        chk("s2_one3_dout", 32'(b_dout), 1);
        chk("s2_one3_pulse", 32'(b_pulse), 1);
        chk("s2_one3_cnt", 32'(b_cnt), 1);

        // RUN_LEN=2 MODE0: en 1,0,1 with D_in 1,0,1
        do_reset();
        tick(1'b1, 1'b1);
        chk("s3_e1_len", 32'(c_len), 1);
        tick(1'b0, 1'b0);
        chk("s3_e2_len", 32'(c_len), 1);
        chk("s3_e2_bit", 32'(c_bit), 1);
        chk("s3_e2_dout", 32'(c_dout), 0);
        tick(1'b1, 1'b1);
        chk("s3_e3_dout", 32'(c_dout), 1);
        chk("s3_e3_pulse", 32'(c_pulse), 1);
        chk("s3_e3_cnt", 32'(c_cnt), 1);
        tick(1'b0, 1'b0);
        chk("s3_hold_pulse", 32'(c_pulse), 0);
        chk("s3_hold_dout", 32'(c_dout), 1);

        // Reset mid-run (RUN_LEN=3)
        do_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("s4_pre_len", 32'(a_len), 2);
        reset = 1'b1;
        tick(1'b1, 1'b1);
        reset = 1'b0;
        chk("s4_rst_len", 32'(a_len), 0);
        tick(1'b1, 1'b1);
        chk("s4_dout", 32'(a_dout), 0);
        chk("s4_len", 32'(a_len), 1);
        chk("s4_cnt", 32'(a_cnt), 0);

        // CNT_W=2 saturation over six runs, then clear coincident with a pulse
        do_reset();
        for (int k = 0; k < 6; k++) begin
            logic bv;
            bv = (k % 2 == 0);
            tick(1'b1, bv);
            tick(1'b1, bv);
            chk($sformatf("s5_run%0d_pulse", k), 32'(c_pulse), 1);
            chk($sformatf("s5_run%0d_cnt", k), 32'(c_cnt), (k < 3) ? k + 1 : 3);
        end
        tick(1'b1, 1'b1);
        clr_count = 1'b1;
        tick(1'b1, 1'b1);
        clr_count = 1'b0;
        chk("s5_clr_pulse", 32'(c_pulse), 1);
        chk("s5_clr_cnt", 32'(c_cnt), 0);

        // RUN_LEN=4 MODE2: ten 0s
        do_reset();
        hi = 0;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0);
            if (d_dout) hi++;
            if (d_pulse) np++;
        end
        chk("s6_hi_cycles", 32'(hi), 7);
        chk("s6_pulses", 32'(np), 1);
        chk("s6_len", 32'(d_len), 4);
        chk("s6_cnt", 32'(d_cnt), 1);
        tick(1'b1, 1'b1);
        chk("s6_end_dout", 32'(d_dout), 0);
        chk("s6_end_len", 32'(d_len), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
